// File: rtl/rs_command_debouncer_pkg.sv
// Shared constants and helpers for the push-button command front-ends.
// Every button channel and the command arbiter import this package.
package rs_command_debouncer_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEFAULT_CNT_WIDTH       = 16;

    localparam logic SYNC_RESET_VAL = 1'b0;
    localparam logic DB_RESET_VAL   = 1'b0;
    localparam logic CMD_RESET_VAL  = 1'b0;

    typedef struct packed {
        logic s;
        logic r;
        logic conflict;
    } rs_cmd_t;

    localparam rs_cmd_t CMD_RESET = '{
        s:        CMD_RESET_VAL,
        r:        CMD_RESET_VAL,
        conflict: CMD_RESET_VAL
    };

    // Simultaneous requests are both dropped so the flip-flop never sees S=R=1.
    function automatic rs_cmd_t arbitrate(input logic set_req,
                                          input logic clr_req);
        rs_cmd_t cmd;
        cmd          = CMD_RESET;
        cmd.s        = set_req & ~clr_req;
        cmd.r        = clr_req & ~set_req;
        cmd.conflict = set_req & clr_req;
        return cmd;
    endfunction

endpackage

// File: rtl/rs_command_debouncer_debounce_channel.sv
// One button front-end: two-flop synchronizer, stability counter,
// accepted level and a rising-edge request pulse.
module debounce_channel
    import rs_command_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic req_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 db_q;
    logic                 db_d;
    logic                 db_dly_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= SYNC_RESET_VAL;
            sync2_q <= SYNC_RESET_VAL;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Any sample matching the current level restarts the stability run.
    always_comb begin
        db_d  = db_q;
        cnt_d = CNT_ZERO;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_q     <= DB_RESET_VAL;
            db_dly_q <= DB_RESET_VAL;
            cnt_q    <= CNT_ZERO;
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign req_o = db_q & ~db_dly_q;

endmodule

// File: rtl/rs_command_debouncer.sv
// Debounces the set/clear buttons and issues mutually exclusive
// one-cycle S/R commands, flagging same-cycle collisions.
module rs_command_debouncer
    import rs_command_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_BTN,
    input  logic CLR_BTN,
    output logic S,
    output logic R,
    output logic CONFLICT
);

    logic    set_req;
    logic    clr_req;
    rs_cmd_t cmd_d;
    rs_cmd_t cmd_q;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_set_ch (
        .clk_i (CLK),
        .rst_i (RST),
        .btn_i (SET_BTN),
        .req_o (set_req)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_clr_ch (
        .clk_i (CLK),
        .rst_i (RST),
        .btn_i (CLR_BTN),
        .req_o (clr_req)
    );

    always_comb begin
        cmd_d = arbitrate(set_req, clr_req);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_q <= CMD_RESET;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign S        = cmd_q.s;
    assign R        = cmd_q.r;
    assign CONFLICT = cmd_q.conflict;

endmodule

// File: tb/tb_rs_command_debouncer.sv
// Bench for rs_command_debouncer: N=4 and N=1 instances share stimulus
// and are checked against a sliding-window model of the button history.
module tb_rs_command_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_btn = 1'b0;
    logic clr_btn = 1'b0;
    logic s4, r4, c4;
    logic s1, r1, c1;

    int total = 0;
    int bad = 0;

    bit hq[2][2][$];
    bit mdb[2][2];
    bit mreq[2][2];
    bit es[2];
    bit er[2];
    bit ec[2];
    int nval[2] = '{4, 1};

    always #5 clk = ~clk;

    rs_command_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (16)
    ) u_dut4 (
        .CLK      (clk),
        .RST      (rst),
        .SET_BTN  (set_btn),
        .CLR_BTN  (clr_btn),
        .S        (s4),
        .R        (r4),
        .CONFLICT (c4)
    );

    rs_command_debouncer #(
        .DEBOUNCE_CYCLES (1),
        .CNT_WIDTH       (16)
    ) u_dut1 (
        .CLK      (clk),
        .RST      (rst),
        .SET_BTN  (set_btn),
        .CLR_BTN  (clr_btn),
        .S        (s1),
        .R        (r1),
        .CONFLICT (c1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A level is accepted once the last N synchronized samples all
    // differ from it; the synchronizer delays a sample by two edges.
    task automatic model_edge(input bit rs, input bit sb, input bit cb);
        for (int d = 0; d < 2; d++) begin
            if (rs) begin
                es[d] = 1'b0;
                er[d] = 1'b0;
                ec[d] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    hq[d][c].delete();
                    mdb[d][c] = 1'b0;
                    mreq[d][c] = 1'b0;
                end
            end else begin
                es[d] = mreq[d][0] & ~mreq[d][1];
                er[d] = mreq[d][1] & ~mreq[d][0];
                ec[d] = mreq[d][0] & mreq[d][1];
                for (int c = 0; c < 2; c++) begin
                    bit b;
                    bit all_diff;
                    bit new_db;
                    int len;
                    b = (c == 0) ? sb : cb;
                    hq[d][c].push_back(b);
                    if (hq[d][c].size() > 16) void'(hq[d][c].pop_front());
                    len = hq[d][c].size();
                    all_diff = 1'b1;
                    for (int j = 0; j < nval[d]; j++) begin
                        int idx;
                        bit v;
                        idx = len - 3 - j;
                        v = (idx >= 0) ? hq[d][c][idx] : 1'b0;
                        if (v == mdb[d][c]) all_diff = 1'b0;
                    end
                    new_db = all_diff ? ~mdb[d][c] : mdb[d][c];
                    mreq[d][c] = new_db & ~mdb[d][c];
                    mdb[d][c] = new_db;
                end
            end
        end
    endtask

    task automatic step(input bit rs, input bit sb, input bit cb);
        rst = rs;
        set_btn = sb;
        clr_btn = cb;
        @(posedge clk);
        #1;
        model_edge(rs, sb, cb);
        chk("S_n4", s4, es[0]);
        chk("R_n4", r4, er[0]);
        chk("CONFLICT_n4", c4, ec[0]);
        chk("S_n1", s1, es[1]);
        chk("R_n1", r1, er[1]);
        chk("CONFLICT_n1", c1, ec[1]);
        chk("excl_n4", s4 & r4, 1'b0);
        chk("excl_n1", s1 & r1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit sb;
        bit cb;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("reset_S", s4, 1'b0);
        chk("reset_R", r4, 1'b0);
        chk("reset_CONFLICT", c4, 1'b0);

        // held press: single pulse 6 edges after first sample
        idle(7);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("held_S", s4, 1'(i == 6));
            chk("held_R", r4, 1'b0);
            chk("held_CONFLICT", c4, 1'b0);
        end
        idle(10);

        // bouncing then stable hold
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'(i % 2 == 0), 1'b0);
            chk("bounce_S", s4, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("bounce_hold_S", s4, 1'(i == 6));
        end
        idle(10);

        // simultaneous presses collide
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("both_CONFLICT", c4, 1'(i == 6));
            chk("both_S", s4, 1'b0);
            chk("both_R", r4, 1'b0);
        end
        idle(10);

        // clear one cycle after set
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'(i >= 1));
            chk("offset_S", s4, 1'(i == 6));
            chk("offset_R", r4, 1'(i == 7));
            chk("offset_CONFLICT", c4, 1'b0);
        end
        idle(10);

        // reset in the middle of a debounce, button kept held
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("rst_mid_S", s4, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("rst_resume_S", s4, 1'(i == 6));
        end
        idle(10);

        // N=1 press/release/press with 3-cycle gaps
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'((i < 3) || (i >= 6 && i < 9)), 1'b0);
            chk("n1_S", s1, 1'((i == 3) || (i == 9)));
        end
        idle(10);

        // random bouncy buttons with occasional reset
        sb = 1'b0;
        cb = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) sb = ~sb;
            if ($urandom_range(0, 5) == 0) cb = ~cb;
            step(1'($urandom_range(0, 99) == 0), sb, cb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
